// File: rtl/contactor_sequencer.sv
// Contactor sequencer: synchronizes SPI-domain requests and switches one channel at a time,
// confirming every transition against 2-bit router feedback with timeout and fault latching.
module contactor_sequencer #(
    parameter int NUM_CH        = 21,
    parameter int FB_TIMEOUT    = 50000,
    parameter int SETTLE_CYCLES = 1000,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_CH-1:0]     spi_requests,
    input  logic                  reset_req,
    input  logic                  clear_errors,
    input  logic                  shutdown,
    input  logic [2*NUM_CH-1:0]   router_feedback,
    output logic [NUM_CH-1:0]     contactor_drive,
    output logic [NUM_CH-1:0]     contactor_status,
    output logic [NUM_CH-1:0]     fault_mask,
    output logic                  feedback_timeout_error,
    output logic                  invalid_request,
    output logic                  busy
);

    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_MAX = (FB_TIMEOUT > SETTLE_CYCLES) ? FB_TIMEOUT : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] FB_LAST     = CNT_W'(FB_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CH_W-1:0]  LAST_CH     = CH_W'(NUM_CH - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAIT_FB = 2'd1;
    localparam logic [1:0] SETTLE  = 2'd2;

    logic [NUM_CH-1:0]      req_sync [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] rst_sync;
    logic [SYNC_STAGES-1:0] clr_sync;
    logic                   rst_s_d;

    logic [NUM_CH-1:0]      req_s;
    logic                   rst_s;
    logic                   clr_s;
    logic                   rst_rise;

    logic [1:0]             state;
    logic [CNT_W-1:0]       cnt;
    logic [CH_W-1:0]        rr_ptr;
    logic [CH_W-1:0]        cur_ch;
    logic                   tgt;

    logic [NUM_CH-1:0]      fb_closed;
    logic [NUM_CH-1:0]      fb_open;
    logic [NUM_CH-1:0]      pending;
    logic [NUM_CH-1:0]      blocked;
    logic                   fb_match;
    logic                   sel_valid;
    logic [CH_W-1:0]        sel_ch;
    logic [CH_W-1:0]        cand_idx;
    int                     cand;
    logic                   flag_clear;

    // Every SPI-domain input gets its own flop chain; reset_req also gets an edge-detect flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                req_sync[s] <= '0;
            end
            rst_sync <= '0;
            clr_sync <= '0;
            rst_s_d  <= 1'b0;
        end else begin
            req_sync[0] <= spi_requests;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                req_sync[s] <= req_sync[s-1];
            end
            rst_sync <= {rst_sync[SYNC_STAGES-2:0], reset_req};
            clr_sync <= {clr_sync[SYNC_STAGES-2:0], clear_errors};
            rst_s_d  <= rst_s;
        end
    end

    assign req_s    = req_sync[SYNC_STAGES-1];
    assign rst_s    = rst_sync[SYNC_STAGES-1];
    assign clr_s    = clr_sync[SYNC_STAGES-1];
    assign rst_rise = rst_s & ~rst_s_d;

    always_comb begin
        fb_closed = '0;
        fb_open   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            fb_closed[i] = (router_feedback[2*i +: 2] == 2'b10);
            fb_open[i]   = (router_feedback[2*i +: 2] == 2'b01);
        end
    end

    assign blocked  = req_s & fault_mask;
    assign pending  = (req_s ^ contactor_drive) & ~blocked;
    assign fb_match = tgt ? fb_closed[cur_ch] : fb_open[cur_ch];

    // Round-robin scan starting at rr_ptr so a busy low channel cannot starve the rest.
    always_comb begin
        sel_valid = 1'b0;
        sel_ch    = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_CH) begin
                cand = cand - NUM_CH;
            end
            cand_idx = CH_W'(cand);
            if (!sel_valid && pending[cand_idx]) begin
                sel_valid = 1'b1;
                sel_ch    = cand_idx;
            end
        end
    end

    // A reset_req edge that coincides with shutdown is absorbed by shutdown, faults included.
    assign flag_clear = clr_s | (rst_rise & ~shutdown);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                  <= IDLE;
            cnt                    <= '0;
            rr_ptr                 <= '0;
            cur_ch                 <= '0;
            tgt                    <= 1'b0;
            contactor_drive        <= '0;
            fault_mask             <= '0;
            feedback_timeout_error <= 1'b0;
            invalid_request        <= 1'b0;
        end else begin
            if (shutdown || rst_rise) begin
                contactor_drive <= '0;
                state           <= IDLE;
                cnt             <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (sel_valid) begin
                            contactor_drive[sel_ch] <= req_s[sel_ch];
                            tgt    <= req_s[sel_ch];
                            cur_ch <= sel_ch;
                            cnt    <= '0;
                            rr_ptr <= (sel_ch == LAST_CH) ? '0 : sel_ch + CH_W'(1);
                            state  <= WAIT_FB;
                        end
                    end
                    WAIT_FB: begin
                        if (fb_match) begin
                            cnt   <= '0;
                            state <= SETTLE;
                        end else if (cnt == FB_LAST) begin
                            contactor_drive[cur_ch] <= 1'b0;
                            fault_mask[cur_ch]      <= 1'b1;
                            feedback_timeout_error  <= 1'b1;
                            cnt                     <= '0;
                            state                   <= SETTLE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    SETTLE: begin
                        if (cnt == SETTLE_LAST) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        cnt   <= '0;
                        state <= IDLE;
                    end
                endcase
            end

            if (|blocked) begin
                invalid_request <= 1'b1;
            end

            // Placed last so a clear beats any set landing in the same cycle.
            if (flag_clear) begin
                fault_mask             <= '0;
                feedback_timeout_error <= 1'b0;
                invalid_request        <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            contactor_status <= '0;
        end else begin
            contactor_status <= contactor_drive & fb_closed;
        end
    end

    assign busy = (state != IDLE);

endmodule
